// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl: pipeline hazard / redirect controller.
//
// Turns per-stage stall requests into a per-stage hold vector (a stage that
// stalls also holds every stage upstream of it). It converts exception or
// redirect requests into a registered one-cycle flush strobe that carries the
// redirect target. It also keeps a saturating count of stalled cycles.
//
// Optional feature: define STALL_WDOG_EN to compile in a stall watchdog. The
// watchdog raises a sticky timeout after WDOG_MAX consecutive stalled cycles.
// Without the macro, timeout_o is tied low.
//
// Ports:
//   clk_i           rising-edge clock for all state
//   rst             synchronous, active-high reset
//   stallreq_i      per-stage stall request, bit 0 = PC stage
//   flush_req_i     exception/redirect request (pulse or level)
//   flush_pc_i      redirect target, sampled together with flush_req_i
//   stall_o         per-stage hold vector, combinational, 1 = hold
//   flush_o         registered one-cycle flush strobe
//   new_pc_o        registered redirect target, valid while flush_o = 1
//   stall_cycles_o  saturating count of cycles with any stall_o bit set
//   timeout_o       sticky watchdog flag
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int unsigned NSTAGE   = 6,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned WDOG_MAX = 255,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stallreq_i,
  input  logic              flush_req_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  output logic [NSTAGE-1:0] stall_o,
  output logic              flush_o,
  output logic [ADDR_W-1:0] new_pc_o,
  output logic [CNT_W-1:0]  stall_cycles_o,
  output logic              timeout_o
);

  typedef enum logic [1:0] {
    StRun,
    StStall,
    StFlush
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] new_pc_q, new_pc_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [NSTAGE-1:0] stall_therm;
  logic              any_stall;

  // A stall at stage k must also hold every upstream stage, so stall_o is the
  // prefix-OR of the requests taken from the writeback end downwards.
  always_comb begin
    stall_therm = '0;
    stall_therm[NSTAGE-1] = stallreq_i[NSTAGE-1];
    for (int i = int'(NSTAGE) - 2; i >= 0; i--) begin
      stall_therm[i] = stall_therm[i+1] | stallreq_i[i];
    end
  end

  // The flush cycle squashes everything, so nothing may be held during it.
  assign stall_o   = (rst || (state_q == StFlush)) ? '0 : stall_therm;
  assign any_stall = |stall_o;

  // A flush request overrides any stall request from every state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun, StStall, StFlush: begin
        if (flush_req_i) begin
          state_d = StFlush;
        end else if (|stallreq_i) begin
          state_d = StStall;
        end else begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    new_pc_d       = new_pc_q;
    stall_cycles_d = stall_cycles_q;
    if (flush_req_i) begin
      new_pc_d = flush_pc_i;
    end
    if (any_stall && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q        <= StRun;
      new_pc_q       <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      new_pc_q       <= new_pc_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign flush_o        = (state_q == StFlush);
  assign new_pc_o       = new_pc_q;
  assign stall_cycles_o = stall_cycles_q;

`ifdef STALL_WDOG_EN
  localparam int unsigned WdogW = (WDOG_MAX < 1) ? 1 : $clog2(WDOG_MAX + 1);
  localparam logic [WdogW-1:0] WdogLim = WdogW'(WDOG_MAX);

  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             timeout_q, timeout_d;

  // The count parks at the limit, so the flag can be latched one edge after
  // the limit is reached even if the stall drops in that same cycle.
  always_comb begin
    wdog_d    = wdog_q;
    timeout_d = timeout_q | (wdog_q == WdogLim);
    if (!any_stall || flush_req_i) begin
      wdog_d = '0;
    end else if (wdog_q != WdogLim) begin
      wdog_d = wdog_q + WdogW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_wdog_max;
  assign unused_wdog_max = ^WDOG_MAX;
  assign timeout_o       = 1'b0;
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL provide parameter NSTAGE, default 6, number of pipeline stages; bit 0 = PC stage, bit NSTAGE-1 = writeback.
REQ-002 SHALL provide parameter ADDR_W, default 32, width of the flush target address.
REQ-003 SHALL provide parameter WDOG_MAX, default 255, consecutive-stall cycle limit before timeout.
REQ-004 SHALL provide parameter CNT_W, default 32, width of the stall performance counter.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 stallreq  input  NSTAGE  per-stage stall request; bit i raised by stage i.
REQ-008 flush_req  input  1  exception/redirect request, one-cycle pulse or level.
REQ-009 flush_pc  input  ADDR_W  redirect target, sampled with flush_req.
REQ-010 stall  output  NSTAGE  per-stage hold vector; 1 = stage holds its register.
REQ-011 flush  output  1  registered one-cycle pipeline flush strobe.
REQ-012 new_pc  output  ADDR_W  registered redirect target, valid while flush=1.
REQ-013 stall_cycles  output  CNT_W  saturating count of cycles with any stall bit set.
REQ-014 timeout  output  1  sticky watchdog flag.

Function
REQ-015 FSM states: RUN, STALL, FLUSH; reset state RUN.
REQ-016 Stall vector: k = highest index with stallreq[k]=1; stall[k:0]=1, stall[NSTAGE-1:k+1]=0; no request -> stall=0.
REQ-017 stall is combinational from stallreq and FSM state, zero-cycle latency.
REQ-018 In FLUSH, stall SHALL be forced to all-zero regardless of stallreq.
REQ-019 flush_req=1 at edge t -> flush=1 and new_pc=flush_pc (sampled at t) during cycle t+1, state FLUSH.
REQ-020 flush deasserts after one cycle unless flush_req=1 again in the FLUSH cycle; back-to-back requests give consecutive flush cycles, new_pc updating each.
REQ-021 flush_req and nonzero stallreq at same edge: flush wins; next state FLUSH.
REQ-022 Transitions: RUN->STALL when stallreq!=0 and flush_req=0; STALL->RUN when stallreq=0; any->FLUSH on flush_req; FLUSH->STALL/RUN per stallreq when flush_req=0.
REQ-023 new_pc SHALL hold its last value when flush=0.
REQ-024 stall_cycles increments by 1 each cycle stall!=0; saturates at all-ones, never wraps.
REQ-025 Bits of stallreq at index 0 alone SHALL yield stall=1 at bit 0 only.

Reset
REQ-026 rst=1 at edge: state RUN, flush=0, new_pc=0, stall_cycles=0, timeout=0, watchdog count=0.
REQ-027 While rst=1, stall SHALL be all-zero combinationally.
REQ-028 rst asserted during FLUSH or STALL SHALL abort it at the next edge; pending flush_req at that edge is dropped.

Configuration
REQ-029 Macro STALL_WDOG_EN SHALL compile in the watchdog.
REQ-030 With STALL_WDOG_EN: counter counts consecutive cycles with stall!=0, clears on a stall-free cycle or flush; reaching WDOG_MAX sets timeout=1 next edge, held until rst.
REQ-031 Without STALL_WDOG_EN: no watchdog counter, timeout tied 0.

Verification
REQ-032 Reset then stallreq=6'b001000 -> stall=6'b001111 same cycle, stall_cycles increments each cycle.
REQ-033 stallreq=6'b000100 and 6'b001100 in turn -> stall=6'b000111 then 6'b001111; stallreq=0 -> stall=0, state RUN.
REQ-034 flush_req=1, flush_pc=32'h0000_0100, stallreq=6'b001000 same edge -> next cycle flush=1, new_pc=32'h100, stall=0; following cycle flush=0, stall=6'b001111.
REQ-035 flush_req held 3 cycles with flush_pc 0x10,0x20,0x30 -> flush=1 for 3 cycles, new_pc 0x10,0x20,0x30.
REQ-036 STALL_WDOG_EN, WDOG_MAX=4, stallreq=6'b000100 held 4 cycles -> timeout=1 and stays 1 after stallreq=0 until rst.
REQ-037 rst=1 mid-FLUSH -> next cycle flush=0, new_pc=0, stall_cycles=0, timeout=0.
